// File: rtl/my_cpu_pkg.sv
// Shared definitions for the my_cpu teaching CPU.
//   WORD_W      default datapath / register / outResult width
//   IMEM_DEPTH  instruction ROM depth (8-bit pc)
//   opcode_e    4-bit instruction opcodes
//   stage_e     IF/ID/EX/MEM/WB stage encodings
//   helpers     ALU-result / register-write classification, 7-seg digit encoder
package my_cpu_pkg;

   localparam int WORD_W     = 16;
   localparam int IMEM_DEPTH = 256;
   localparam int DMEM_DEPTH = 256;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND = 4'h3,
      OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_SHL  = 4'h6, OP_SHR = 4'h7,
      OP_LDI  = 4'h8, OP_ADDI = 4'h9, OP_LD   = 4'hA, OP_ST  = 4'hB,
      OP_JMP  = 4'hC, OP_BZ   = 4'hD, OP_NOP2 = 4'hE, OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_MEM = 3'd3, ST_WB = 3'd4
   } stage_e;

   // Opcodes whose EX stage produces outResult (ADD..ADDI).
   function automatic logic alu_writes(input opcode_e op);
      return (op >= OP_ADD) && (op <= OP_ADDI);
   endfunction

   // Opcodes that write r[rd] at WB.
   function automatic logic writes_rd(input opcode_e op);
      return alu_writes(op) || (op == OP_LD);
   endfunction

   // Active-low {dp,g,f,e,d,c,b,a}, dp off; anything outside 0..4 shows 0.
   function automatic logic [7:0] seg7(input logic [2:0] d);
      case (d)
         3'd1:    return 8'hF9;
         3'd2:    return 8'hA4;
         3'd3:    return 8'hB0;
         3'd4:    return 8'h99;
         default: return 8'hC0;
      endcase
   endfunction

endpackage

// File: rtl/my_cpu_if.sv
// Board-facing signal bundle of my_cpu.
//   isAuto, nextStage          : run-mode switch and step button (driven by master)
//   b2d, leds, stage, outResult: stage display and result (driven by the CPU, slave)
interface my_cpu_if import my_cpu_pkg::*; #(
   parameter int WORD_SIZE = WORD_W
);
   logic                 isAuto;
   logic                 nextStage;
   logic [7:0]           b2d;
   logic [7:0]           leds;
   logic [2:0]           stage;
   logic [WORD_SIZE-1:0] outResult;

   modport master (output isAuto, nextStage, input b2d, leds, stage, outResult);
   modport slave  (input isAuto, nextStage, output b2d, leds, stage, outResult);
endinterface

// File: rtl/my_cpu_alu.sv
// Combinational ALU for my_cpu.
//   op_i      opcode of the instruction in EX
//   a_i, b_i  r[rs], r[rt] latched at ID
//   c_i       r[rd] latched at ID (ADDI source)
//   imm8_i    instruction bits [7:0]
//   result_o  value for outResult (0 for opcodes without an ALU result)
module my_cpu_alu import my_cpu_pkg::*; #(
   parameter int W = WORD_W
) (
   input  opcode_e      op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   input  logic [7:0]   imm8_i,
   output logic [W-1:0] result_o
);
   always_comb begin
      result_o = '0;
      case (op_i)
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_SHL:  result_o = a_i << b_i[3:0];
         OP_SHR:  result_o = a_i >> b_i[3:0];
         OP_LDI:  result_o = W'(imm8_i);
         OP_ADDI: result_o = c_i + W'(imm8_i);
         default: result_o = '0;
      endcase
   end
endmodule

// File: rtl/my_cpu.sv
// Multi-cycle 16-bit teaching CPU: IF, ID, EX, MEM, WB, one stage per clk
// (isAuto=1) or per rising edge of nextStage (isAuto=0).
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   io   my_cpu_if.slave: isAuto, nextStage in; b2d, leds, stage, outResult out
// Instruction ROM contents come from the device image (the ROM array has no
// write port); data RAM is not reset.
module my_cpu import my_cpu_pkg::*; #(
   parameter int WORD_SIZE = WORD_W
) (
   input  logic      clk,
   input  logic      rst,
   my_cpu_if.slave   io
);
   logic [15:0]          rom    [IMEM_DEPTH];
   logic [WORD_SIZE-1:0] dmem_q [DMEM_DEPTH];
   logic [WORD_SIZE-1:0] regs_q [8];

   stage_e               stage_q, stage_d;
   logic [7:0]           pc_q;
   logic [15:0]          ir_q;
   logic [WORD_SIZE-1:0] a_q, b_q, c_q, res_q;
   logic                 halted_q, ns_q;
   logic                 adv;
   logic [WORD_SIZE-1:0] alu_res;
   logic [2:0]           stage_disp;

   opcode_e    op;
   logic [2:0] rd, rs, rt;
   logic [7:0] imm8;
   logic       unused_ir11;

   assign op          = opcode_e'(ir_q[15:12]);
   assign rd          = ir_q[10:8];
   assign rs          = ir_q[6:4];
   assign rt          = ir_q[2:0];
   assign imm8        = ir_q[7:0];
   assign unused_ir11 = ir_q[11];

   // ns_q resets to 1 so a button held through reset does not count as a press.
   assign adv = !halted_q && (io.isAuto || (io.nextStage && !ns_q));

   my_cpu_alu #(.W(WORD_SIZE)) u_alu (
      .op_i    (op),
      .a_i     (a_q),
      .b_i     (b_q),
      .c_i     (c_q),
      .imm8_i  (imm8),
      .result_o(alu_res)
   );

   always_comb begin
      stage_d = stage_q;
      if (adv) begin
         case (stage_q)
            ST_IF:   stage_d = ST_ID;
            ST_ID:   stage_d = ST_EX;
            ST_EX:   stage_d = ST_MEM;
            ST_MEM:  stage_d = ST_WB;
            default: stage_d = ST_IF;   // WB and unreachable 5..7
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q  <= ST_IF;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         res_q    <= '0;
         halted_q <= 1'b0;
         ns_q     <= 1'b1;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         ns_q    <= io.nextStage;
         stage_q <= stage_d;
         if (adv) begin
            case (stage_q)
               ST_IF: begin
                  ir_q <= rom[pc_q];
                  pc_q <= pc_q + 8'd1;
               end
               ST_ID: begin
                  a_q <= regs_q[rs];
                  b_q <= regs_q[rt];
                  c_q <= regs_q[rd];
               end
               ST_EX: begin
                  if (alu_writes(op)) res_q <= alu_res;
                  if (op == OP_JMP || (op == OP_BZ && c_q == '0)) pc_q <= imm8;
               end
               ST_MEM: begin
                  if (op == OP_LD) res_q <= dmem_q[a_q[7:0]];
               end
               ST_WB: begin
                  if (writes_rd(op)) regs_q[rd] <= res_q;
                  if (op == OP_HALT) halted_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Data RAM kept in its own unreset process so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (adv && stage_q == ST_MEM && op == OP_ST) dmem_q[a_q[7:0]] <= c_q;
   end

   assign stage_disp   = (stage_q > ST_WB) ? 3'd0 : stage_q;
   assign io.stage     = stage_disp;
   assign io.b2d       = seg7(stage_disp);
   assign io.leds      = res_q[7:0];
   assign io.outResult = res_q;

endmodule

// File: tb/tb_my_cpu.sv
module tb_my_cpu;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   my_cpu_if #(.WORD_SIZE(16)) bus ();
   my_cpu #(.WORD_SIZE(16)) dut (.clk(clk), .rst(rst), .io(bus));

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) dut.rom[i] = 16'h0000;
   endtask

   task automatic poke(input int addr, input logic [15:0] v);
      dut.rom[addr] = v;
   endtask

   task automatic load_prog(input logic [15:0] prog[$]);
      clear_rom();
      for (int i = 0; i < prog.size(); i++) dut.rom[i] = prog[i];
   endtask

   // Ends at a negedge with rst released and stage=0.
   task automatic apply_reset(input logic autom);
      @(negedge clk);
      rst = 1'b1;
      bus.isAuto = autom;
      bus.nextStage = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      bus.nextStage = 1'b1;
      @(negedge clk);
      bus.nextStage = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] segs [5];
      segs = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99};
      clear_rom();
      apply_reset(1'b1);
      n_cmp++; if (bus.stage !== 3'd0) begin n_err++; $display("FAIL reset_stage got %0d want 0", bus.stage); end
      n_cmp++; if (bus.outResult !== 16'h0000) begin n_err++; $display("FAIL reset_result got %h want 0000", bus.outResult); end
      n_cmp++; if (bus.leds !== 8'h00) begin n_err++; $display("FAIL reset_leds got %h want 00", bus.leds); end
      n_cmp++; if (bus.b2d !== 8'hC0) begin n_err++; $display("FAIL reset_b2d got %h want C0", bus.b2d); end
      for (int k = 1; k <= 5; k++) begin
         run(1);
         n_cmp++; if (bus.stage !== 3'(k % 5)) begin n_err++; $display("FAIL auto_stage step %0d got %0d want %0d", k, bus.stage, k % 5); end
         n_cmp++; if (bus.b2d !== segs[k % 5]) begin n_err++; $display("FAIL auto_b2d step %0d got %h want %h", k, bus.b2d, segs[k % 5]); end
      end
   endtask

   task automatic test_prog_basic();
      load_prog('{16'h8105, 16'h8203, 16'h1012, 16'hF000});
      apply_reset(1'b1);
      run(5);
      n_cmp++; if (bus.outResult !== 16'h0005) begin n_err++; $display("FAIL ldi_r1 got %h want 0005", bus.outResult); end
      run(5);
      n_cmp++; if (bus.outResult !== 16'h0003) begin n_err++; $display("FAIL ldi_r2 got %h want 0003", bus.outResult); end
      run(5);
      n_cmp++; if (bus.outResult !== 16'h0008) begin n_err++; $display("FAIL add got %h want 0008", bus.outResult); end
      n_cmp++; if (bus.leds !== 8'h08) begin n_err++; $display("FAIL add_leds got %h want 08", bus.leds); end
      run(5);
      n_cmp++; if (dut.halted_q !== 1'b1) begin n_err++; $display("FAIL halt_flag got %b want 1", dut.halted_q); end
      run(10);
      n_cmp++; if (bus.stage !== 3'd0) begin n_err++; $display("FAIL halt_freeze got %0d want 0", bus.stage); end
      n_cmp++; if (dut.regs_q[0] !== 16'h0008) begin n_err++; $display("FAIL add_wb_r0 got %h want 0008", dut.regs_q[0]); end
      n_cmp++; if (bus.outResult !== 16'h0008) begin n_err++; $display("FAIL halt_result got %h want 0008", bus.outResult); end
   endtask

   task automatic test_arith();
      load_prog('{16'h8103, 16'h8205, 16'h2312, 16'h8401, 16'h850F, 16'h6645,
                  16'h2704, 16'h9701, 16'h7165, 16'h5234, 16'hF000});
      apply_reset(1'b1);
      run(15);
      n_cmp++; if (bus.outResult !== 16'hFFFE) begin n_err++; $display("FAIL sub_wrap got %h want FFFE", bus.outResult); end
      run(15);
      n_cmp++; if (bus.outResult !== 16'h8000) begin n_err++; $display("FAIL shl15 got %h want 8000", bus.outResult); end
      run(5);
      n_cmp++; if (bus.outResult !== 16'hFFFF) begin n_err++; $display("FAIL sub_neg1 got %h want FFFF", bus.outResult); end
      run(5);
      n_cmp++; if (bus.outResult !== 16'h0000) begin n_err++; $display("FAIL addi_wrap got %h want 0000", bus.outResult); end
      run(5);
      n_cmp++; if (bus.outResult !== 16'h0001) begin n_err++; $display("FAIL shr15 got %h want 0001", bus.outResult); end
      run(5);
      n_cmp++; if (bus.outResult !== 16'hFFFF) begin n_err++; $display("FAIL xor got %h want FFFF", bus.outResult); end
   endtask

   task automatic test_mem();
      load_prog('{16'h81A5, 16'h8240, 16'hB120, 16'hA320, 16'hF000});
      apply_reset(1'b1);
      run(15);
      n_cmp++; if (bus.outResult !== 16'h0040) begin n_err++; $display("FAIL st_keeps_result got %h want 0040", bus.outResult); end
      run(3);
      n_cmp++; if (bus.outResult !== 16'h0040) begin n_err++; $display("FAIL ld_before_mem got %h want 0040", bus.outResult); end
      run(1);
      n_cmp++; if (bus.outResult !== 16'h00A5) begin n_err++; $display("FAIL ld_at_mem got %h want 00A5", bus.outResult); end
      run(1);
      n_cmp++; if (dut.regs_q[3] !== 16'h00A5) begin n_err++; $display("FAIL ld_wb_r3 got %h want 00A5", dut.regs_q[3]); end
   endtask

   task automatic test_branch();
      clear_rom();
      poke(0, 16'hD00A); poke(1, 16'h8155);
      poke(10, 16'h8177); poke(11, 16'hD10F); poke(12, 16'h8233);
      poke(13, 16'hC014); poke(14, 16'h8266); poke(20, 16'hF000);
      apply_reset(1'b1);
      run(5);
      n_cmp++; if (dut.pc_q !== 8'h0A) begin n_err++; $display("FAIL bz_taken_pc got %h want 0A", dut.pc_q); end
      run(5);
      n_cmp++; if (bus.outResult !== 16'h0077) begin n_err++; $display("FAIL bz_target got %h want 0077", bus.outResult); end
      run(5);
      n_cmp++; if (dut.pc_q !== 8'h0C) begin n_err++; $display("FAIL bz_fall_pc got %h want 0C", dut.pc_q); end
      run(5);
      n_cmp++; if (bus.outResult !== 16'h0033) begin n_err++; $display("FAIL bz_fall_exec got %h want 0033", bus.outResult); end
      run(5);
      n_cmp++; if (dut.pc_q !== 8'h14) begin n_err++; $display("FAIL jmp_pc got %h want 14", dut.pc_q); end
      run(5);
      n_cmp++; if (dut.halted_q !== 1'b1 || bus.outResult !== 16'h0033) begin n_err++; $display("FAIL jmp_skip got halted=%b res=%h want 1/0033", dut.halted_q, bus.outResult); end
      n_cmp++; if (dut.regs_q[1] !== 16'h0077) begin n_err++; $display("FAIL bz_no_fallthrough_r1 got %h want 0077", dut.regs_q[1]); end
   endtask

   task automatic test_wrap();
      clear_rom();
      poke(0, 16'hC0FF); poke(255, 16'h8199);
      apply_reset(1'b1);
      run(5);
      n_cmp++; if (dut.pc_q !== 8'hFF) begin n_err++; $display("FAIL jmp_ff got %h want FF", dut.pc_q); end
      run(5);
      n_cmp++; if (dut.pc_q !== 8'h00) begin n_err++; $display("FAIL pc_wrap got %h want 00", dut.pc_q); end
      n_cmp++; if (bus.outResult !== 16'h0099) begin n_err++; $display("FAIL wrap_exec got %h want 0099", bus.outResult); end
      run(5);
      n_cmp++; if (dut.pc_q !== 8'hFF) begin n_err++; $display("FAIL jmp_loop got %h want FF", dut.pc_q); end
   endtask

   task automatic test_step();
      load_prog('{16'h8105, 16'h8207, 16'h8203, 16'hF000});
      apply_reset(1'b0);
      run(1);
      bus.nextStage = 1'b1;
      run(20);
      n_cmp++; if (bus.stage !== 3'd1) begin n_err++; $display("FAIL step_hold got %0d want 1", bus.stage); end
      bus.nextStage = 1'b0;
      apply_reset(1'b0);
      run(1);
      repeat (3) pulse();
      n_cmp++; if (bus.stage !== 3'd3) begin n_err++; $display("FAIL step_3pulses got %0d want 3", bus.stage); end
      n_cmp++; if (bus.outResult !== 16'h0005) begin n_err++; $display("FAIL step_ex got %h want 0005", bus.outResult); end
      repeat (2) pulse();
      n_cmp++; if (dut.regs_q[1] !== 16'h0005 || bus.stage !== 3'd0) begin n_err++; $display("FAIL step_wb got r1=%h stage=%0d want 0005/0", dut.regs_q[1], bus.stage); end
      repeat (2) pulse();
      bus.isAuto = 1'b1;
      run(1);
      bus.isAuto = 1'b0;
      n_cmp++; if (bus.stage !== 3'd3 || bus.outResult !== 16'h0007) begin n_err++; $display("FAIL mode_switch got stage=%0d res=%h want 3/0007", bus.stage, bus.outResult); end
      run(3);
      n_cmp++; if (bus.stage !== 3'd3) begin n_err++; $display("FAIL step_idle got %0d want 3", bus.stage); end
      repeat (2) pulse();
      n_cmp++; if (dut.regs_q[2] !== 16'h0007) begin n_err++; $display("FAIL step_wb2 got %h want 0007", dut.regs_q[2]); end
      repeat (2) pulse();
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.stage !== 3'd0 || bus.outResult !== 16'h0000) begin n_err++; $display("FAIL rst_mid_ex got stage=%0d res=%h want 0/0000", bus.stage, bus.outResult); end
      n_cmp++; if (dut.regs_q[1] !== 16'h0000 || dut.regs_q[2] !== 16'h0000) begin n_err++; $display("FAIL rst_regs got r1=%h r2=%h want 0000", dut.regs_q[1], dut.regs_q[2]); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.isAuto = 1'b1;
      bus.nextStage = 1'b0;
      rst = 1'b1;
      test_reset();
      test_prog_basic();
      test_arith();
      test_mem();
      test_branch();
      test_wrap();
      test_step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
